alu_operand_loader: RTL

- Board-level front end of the ALU experiment. Loads 32-bit operands A and B byte-serially from the 8 slide switches, and the 3-bit ALU opcode, using two debounced push-buttons.
- Drives A/B/ALU_OP into the combinational ALU.
- On execute, captures the ALU's F/ZF/OF into hold registers. These feed the LED byte-select display stage downstream, so the LEDs show a stable result while operands are re-entered.

---
 rtl/alu_operand_loader_if.sv | 30 +++
 rtl/alu_operand_loader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_operand_loader_if.sv
// Board-side bus of the ALU operand loader: switches, buttons, ALU result in,
// operands and held result out.
interface alu_operand_loader_if;
  logic [7:0]  SW;
  logic        BTN_LOAD;
  logic        BTN_EXEC;
  logic [31:0] F;
  logic        ZF;
  logic        OF;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALU_OP;
  logic [31:0] F_HOLD;
  logic        ZF_HOLD;
  logic        OF_HOLD;
  logic        RES_VALID;
  logic [3:0]  STEP;

  // Loader side: drives operands and the held result.
  modport master (
    input  SW, BTN_LOAD, BTN_EXEC, F, ZF, OF,
    output A, B, ALU_OP, F_HOLD, ZF_HOLD, OF_HOLD, RES_VALID, STEP
  );

  // Board / ALU side.
  modport slave (
    output SW, BTN_LOAD, BTN_EXEC, F, ZF, OF,
    input  A, B, ALU_OP, F_HOLD, ZF_HOLD, OF_HOLD, RES_VALID, STEP
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Byte-serial operand/opcode loader for the ALU experiment with debounced
// load/exec buttons and a held result for the LED display stage.
module alu_operand_loader #(
  parameter int DB_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_operand_loader_if.master  bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  typedef enum logic [3:0] {
    LOAD_A0 = 4'd0, LOAD_A1 = 4'd1, LOAD_A2 = 4'd2, LOAD_A3 = 4'd3,
    LOAD_B0 = 4'd4, LOAD_B1 = 4'd5, LOAD_B2 = 4'd6, LOAD_B3 = 4'd7,
    LOAD_OP = 4'd8, READY   = 4'd9, RESULT  = 4'd10
  } state_t;

  // Index 0 = load button, index 1 = exec button.
  logic [1:0]    raw, s1, s2, deb_level, deb_level_d, press;
  logic [CW-1:0] cnt [2];

  assign raw   = {bus.BTN_EXEC, bus.BTN_LOAD};
  assign press = deb_level & ~deb_level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      deb_level   <= '0;
      deb_level_d <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1          <= raw;
      s2          <= s1;
      deb_level_d <= deb_level;
      for (int unsigned i = 0; i < 2; i++) begin
        if (s2[i] == deb_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          deb_level[i] <= s2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t      state, state_n;
  logic [31:0] a_q, a_n, b_q, b_n, f_q, f_n;
  logic [2:0]  op_q, op_n;
  logic        zf_q, zf_n, of_q, of_n, valid_q, valid_n;

  logic load_p, exec_p;
  assign load_p = press[0];
  assign exec_p = press[1];

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    f_n     = f_q;
    zf_n    = zf_q;
    of_n    = of_q;
    valid_n = valid_q;
    case (state)
      LOAD_A0, LOAD_A1, LOAD_A2, LOAD_A3: begin
        if (load_p) begin
          a_n[{state[1:0], 3'b000} +: 8] = bus.SW;
          state_n = state_t'(state + 4'd1);
        end
      end
      LOAD_B0, LOAD_B1, LOAD_B2, LOAD_B3: begin
        if (load_p) begin
          b_n[{state[1:0], 3'b000} +: 8] = bus.SW;
          state_n = state_t'(state + 4'd1);
        end
      end
      LOAD_OP: begin
        if (load_p) begin
          op_n    = bus.SW[2:0];
          state_n = READY;
        end
      end
      READY, RESULT: begin
        // Exec takes priority over a coincident load once operands are complete.
        if (exec_p) begin
          f_n     = bus.F;
          zf_n    = bus.ZF;
          of_n    = bus.OF;
          valid_n = 1'b1;
          state_n = RESULT;
        end else if (load_p && state == RESULT) begin
          valid_n = 1'b0;
          state_n = LOAD_A0;
        end
      end
      default: state_n = LOAD_A0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD_A0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      f_q     <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      f_q     <= f_n;
      zf_q    <= zf_n;
      of_q    <= of_n;
      valid_q <= valid_n;
    end
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.ALU_OP    = op_q;
  assign bus.F_HOLD    = f_q;
  assign bus.ZF_HOLD   = zf_q;
  assign bus.OF_HOLD   = of_q;
  assign bus.RES_VALID = valid_q;
  assign bus.STEP      = state;

endmodule
